// File: rtl/jpeg_bitstream_unpacker.sv
// jpeg_bitstream_unpacker
// Decode-side front end of the JPEG entropy path. It takes compressed bytes, removes the
// 0x00 stuffed after 0xFF, skips 0xFF fill bytes and stops on a marker. It presents an
// MSB-first bit window from which the Huffman decoder peeks and consumes 1..MAX_GET bits.
//
// Ports:
//   clk, rst_n      clock and asynchronous active-low reset
//   s_data_i/s_valid_i/s_ready_o
//                   byte input with valid/ready handshake
//   get_len_i       bits requested (legal 1..MAX_GET)
//   get_req_i       consume get_len_i bits when bits_valid_o is high
//   bits_out_o      top get_len_i bits of the window, right-aligned
//   bits_valid_o    enough bits buffered for a legal request
//   align_req_i     drop bits up to the next byte boundary
//   bit_count_o     valid bits held in the accumulator
//   marker_found_o  marker detected; input is stalled
//   marker_code_o   second byte of the last marker
//   marker_clear_i  acknowledge the marker and resync (flushes the accumulator)
module jpeg_bitstream_unpacker #(
  parameter int unsigned ACC_W   = 32,
  parameter int unsigned MAX_GET = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  s_data_i,
  input  logic        s_valid_i,
  output logic        s_ready_o,
  input  logic [4:0]  get_len_i,
  input  logic        get_req_i,
  output logic [15:0] bits_out_o,
  output logic        bits_valid_o,
  input  logic        align_req_i,
  output logic [5:0]  bit_count_o,
  output logic        marker_found_o,
  output logic [7:0]  marker_code_o,
  input  logic        marker_clear_i
);

  localparam logic [5:0] AccW     = 6'(ACC_W);
  localparam logic [5:0] MaxGet   = 6'(MAX_GET);
  localparam logic [5:0] ReadyMax = 6'(ACC_W - 8);

  typedef enum logic [1:0] {StData, StFfSeen, StMarker} state_e;

  state_e           state_q, state_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [5:0]       cnt_q, cnt_d;
  logic             found_q, found_d;
  logic [7:0]       code_q, code_d;

  logic [5:0]       len;
  logic [5:0]       win_len;
  logic [ACC_W-1:0] window;
  logic             accept;
  logic             consume;
  logic             append;
  logic [7:0]       append_byte;
  logic [ACC_W-1:0] acc_mid;
  logic [5:0]       cnt_mid;

  assign len     = {1'b0, get_len_i};
  assign win_len = (len > MaxGet) ? MaxGet : len;

  // Valid bits sit MSB-aligned in acc_q and everything below them is kept zero.
  assign s_ready_o    = rst_n && (state_q != StMarker) && (cnt_q <= ReadyMax);
  assign accept       = s_valid_i && s_ready_o;
  assign bits_valid_o = (len != 6'd0) && (len <= MaxGet) && (cnt_q >= len) && !align_req_i;
  assign consume      = get_req_i && bits_valid_o;

  // A shift by the full width yields zero, which covers win_len == 0.
  assign window      = acc_q >> (AccW - win_len);
  assign bits_out_o  = window[15:0];

  assign bit_count_o    = cnt_q;
  assign marker_found_o = found_q;
  assign marker_code_o  = code_q;

  always_comb begin
    state_d     = state_q;
    found_d     = found_q;
    code_d      = code_q;
    append      = 1'b0;
    append_byte = s_data_i;
    case (state_q)
      StData: begin
        if (accept) begin
          if (s_data_i == 8'hFF) state_d = StFfSeen;
          else                   append  = 1'b1;
        end
      end
      StFfSeen: begin
        if (accept) begin
          if (s_data_i == 8'h00) begin
            append      = 1'b1;
            append_byte = 8'hFF;
            state_d     = StData;
          end else if (s_data_i != 8'hFF) begin
            code_d  = s_data_i;
            found_d = 1'b1;
            state_d = StMarker;
          end
        end
      end
      StMarker: begin
        if (marker_clear_i) begin
          found_d = 1'b0;
          state_d = StData;
        end
      end
      default: state_d = StData;
    endcase
  end

  always_comb begin
    acc_mid = acc_q;
    cnt_mid = cnt_q;
    // The partial byte is at the front of the window, so align shifts it out.
    if (align_req_i) begin
      acc_mid = acc_q << cnt_q[2:0];
      cnt_mid = {cnt_q[5:3], 3'b000};
    end else if (consume) begin
      acc_mid = acc_q << len;
      cnt_mid = cnt_q - len;
    end
    acc_d = acc_mid;
    cnt_d = cnt_mid;
    // New byte lands directly after the bits that survive this cycle.
    if (append) begin
      acc_d = acc_mid | ({append_byte, {(ACC_W-8){1'b0}}} >> cnt_mid);
      cnt_d = cnt_mid + 6'd8;
    end
    if ((state_q == StMarker) && marker_clear_i) begin
      acc_d = '0;
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StData;
      acc_q   <= '0;
      cnt_q   <= '0;
      found_q <= 1'b0;
      code_q  <= 8'h00;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      found_q <= found_d;
      code_q  <= code_d;
    end
  end

endmodule

// File: tb/tb_jpeg_bitstream_unpacker.sv
module tb_jpeg_bitstream_unpacker;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  s_data = 8'h00;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [4:0]  get_len = 5'd0;
  logic        get_req = 1'b0;
  logic [15:0] bits_out;
  logic        bits_valid;
  logic        align_req = 1'b0;
  logic [5:0]  bit_count;
  logic        marker_found;
  logic [7:0]  marker_code;
  logic        marker_clear = 1'b0;

  int total = 0;
  int bad   = 0;

  jpeg_bitstream_unpacker #(.ACC_W(32), .MAX_GET(16)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_data_i       (s_data),
    .s_valid_i      (s_valid),
    .s_ready_o      (s_ready),
    .get_len_i      (get_len),
    .get_req_i      (get_req),
    .bits_out_o     (bits_out),
    .bits_valid_o   (bits_valid),
    .align_req_i    (align_req),
    .bit_count_o    (bit_count),
    .marker_found_o (marker_found),
    .marker_code_o  (marker_code),
    .marker_clear_i (marker_clear)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  // Model: a plain queue of pending bits in stream order plus the marker bookkeeping.
  bit          mq[$];
  int          m_mode = 0;  // 0 = data, 1 = after 0xFF, 2 = marker
  logic        m_found = 1'b0;
  logic [7:0]  m_code = 8'h00;
  int          n;
  logic [15:0] ev;
  logic        e_ready;
  logic        e_valid;

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) mq.push_back(b[i]);
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      mq.delete();
      m_mode  = 0;
      m_found = 1'b0;
      m_code  = 8'h00;
      chk("rst_s_ready", s_ready, 0);
      chk("rst_bit_count", bit_count, 0);
      chk("rst_marker_found", marker_found, 0);
      chk("rst_marker_code", marker_code, 0);
    end else begin
      n  = (get_len > 5'd16) ? 16 : int'(get_len);
      ev = 16'h0;
      for (int i = 0; i < n; i++) ev = {ev[14:0], (i < mq.size()) ? mq[i] : 1'b0};
      e_ready = (m_mode != 2) && (mq.size() <= 24);
      e_valid = (get_len >= 5'd1) && (get_len <= 5'd16) && (mq.size() >= int'(get_len))
                && !align_req;
      chk("cyc_bits_out", bits_out, ev);
      chk("cyc_bits_valid", bits_valid, e_valid);
      chk("cyc_bit_count", bit_count, mq.size());
      chk("cyc_s_ready", s_ready, e_ready);
      chk("cyc_marker_found", marker_found, m_found);
      chk("cyc_marker_code", marker_code, m_code);
      if (m_mode == 2 && marker_clear) begin
        mq.delete();
        m_found = 1'b0;
        m_mode  = 0;
      end else begin
        if (align_req) repeat (mq.size() % 8) void'(mq.pop_front());
        else if (get_req && e_valid) repeat (int'(get_len)) void'(mq.pop_front());
        if (s_valid && e_ready) begin
          if (m_mode == 0) begin
            if (s_data == 8'hFF) m_mode = 1;
            else                 push_byte(s_data);
          end else if (m_mode == 1) begin
            if (s_data == 8'h00) begin
              push_byte(8'hFF);
              m_mode = 0;
            end else if (s_data != 8'hFF) begin
              m_code  = s_data;
              m_found = 1'b1;
              m_mode  = 2;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    s_valid = 1'b1;
    s_data  = b;
    tick();
    s_valid = 1'b0;
  endtask

  // Request len bits, check the peeked value literally, then consume.
  task automatic get(input logic [4:0] len, input logic [15:0] exp, input string nm);
    get_len = len;
    get_req = 1'b1;
    #1;
    chk(nm, bits_out, exp);
    tick();
    get_req = 1'b0;
  endtask

  logic [3:0] t1_val [4] = '{4'hA, 4'h5, 4'h3, 4'hC};

  initial begin
    tick();
    tick();
    chk("lit_reset_ready", s_ready, 0);
    rst_n = 1'b1;
    #1;
    chk("lit_reset_count", bit_count, 0);
    chk("lit_ready_after_reset", s_ready, 1);

    // Plain data, nibble gets
    send(8'hA5);
    send(8'h3C);
    for (int i = 0; i < 4; i++) begin
      chk("t1_count", bit_count, 16 - 4 * i);
      get(5'd4, {12'h0, t1_val[i]}, "t1_nibble");
    end
    get_len = 5'd4;
    #1;
    chk("t1_count_end", bit_count, 0);
    chk("t1_valid_end", bits_valid, 0);

    // Stuffed 0x00 after 0xFF
    send(8'hFF);
    send(8'h00);
    send(8'h12);
    chk("t2_count", bit_count, 16);
    get(5'd16, 16'hFF12, "t2_bits");
    chk("t2_count_after", bit_count, 0);

    // Fill bytes then marker
    send(8'h55);
    send(8'hFF);
    send(8'hFF);
    send(8'hD0);
    chk("t3_found", marker_found, 1);
    chk("t3_code", marker_code, 8'hD0);
    chk("t3_ready", s_ready, 0);
    get(5'd8, 16'h0055, "t3_bits");
    marker_clear = 1'b1;
    tick();
    marker_clear = 1'b0;
    #1;
    chk("t3_clear_count", bit_count, 0);
    chk("t3_clear_ready", s_ready, 1);
    chk("t3_clear_found", marker_found, 0);
    chk("t3_code_kept", marker_code, 8'hD0);

    // Full accumulator and back-pressure
    for (int i = 1; i <= 4; i++) send(8'(i));
    chk("t4_count_full", bit_count, 32);
    chk("t4_ready_full", s_ready, 0);
    s_valid = 1'b1;
    s_data  = 8'h05;
    get(5'd8, 16'h0001, "t4_bits");
    chk("t4_count_24", bit_count, 24);
    chk("t4_ready_back", s_ready, 1);
    tick();
    s_valid = 1'b0;
    chk("t4_count_refill", bit_count, 32);
    get(5'd16, 16'h0203, "t4_bits2");
    get(5'd16, 16'h0405, "t4_bits3");

    // Align and illegal lengths
    send(8'hA5);
    send(8'hC3);
    get(5'd3, 16'h0005, "t5_bits3");
    align_req = 1'b1;
    #1;
    chk("t5_align_blocks", bits_valid, 0);
    tick();
    align_req = 1'b0;
    chk("t5_align_count", bit_count, 8);
    get_len = 5'd0;
    get_req = 1'b1;
    #1;
    chk("t5_len0_valid", bits_valid, 0);
    tick();
    chk("t5_len0_count", bit_count, 8);
    get_len = 5'd17;
    #1;
    chk("t5_len17_valid", bits_valid, 0);
    tick();
    get_req = 1'b0;
    chk("t5_len17_count", bit_count, 8);
    get(5'd8, 16'h00C3, "t5_bits8");

    // Align coinciding with a byte accept
    send(8'hA5);
    get(5'd3, 16'h0005, "t5b_bits3");
    align_req = 1'b1;
    s_valid   = 1'b1;
    s_data    = 8'h77;
    tick();
    align_req = 1'b0;
    s_valid   = 1'b0;
    chk("t5b_count", bit_count, 8);
    get(5'd8, 16'h0077, "t5b_bits8");

    // Reset discards a pending 0xFF
    send(8'hFF);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_ready", s_ready, 0);
    tick();
    rst_n = 1'b1;
    send(8'h00);
    get_len = 5'd8;
    #1;
    chk("t6_count", bit_count, 8);
    chk("t6_valid", bits_valid, 1);
    chk("t6_bits", bits_out, 16'h0000);
    chk("t6_found", marker_found, 0);
    tick();
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/jpeg_bitstream_unpacker.md
Name: jpeg_bitstream_unpacker

Overview:
- Decode-side front end of the JPEG entropy path. It is the inverse of the encoder's bit packer and byte stuffer.
- Accepts a byte stream from the compressed-data source.
- Removes stuffed 0x00 bytes that follow 0xFF, skips 0xFF fill bytes, and detects markers.
- Presents an MSB-first bit window from which the Huffman decoder peeks and consumes 1..16 bits per cycle.

Parameters:
- ACC_W, 32, bit accumulator width in bits. Must be at least 24 and a multiple of 8.
- MAX_GET, 16, maximum bits per get request. Must be at most ACC_W-8.

Ports:
- clk  in  1  single clock; all registers on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- s_data  in  8  compressed byte from the source.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  byte is accepted on a cycle where s_valid && s_ready.
- get_len  in  5  number of bits requested; legal values 1..MAX_GET.
- get_req  in  1  consume get_len bits when bits_valid.
- bits_out  out  16  next get_len bits, MSB-first, right-aligned, upper bits zero.
- bits_valid  out  1  bit count >= get_len and the request is legal.
- align_req  in  1  discard bits up to the next byte boundary.
- bit_count  out  6  number of valid bits in the accumulator.
- marker_found  out  1  marker detected; input is stalled.
- marker_code  out  8  second byte of the detected marker.
- marker_clear  in  1  acknowledge marker; resync.

Behaviour:
- Reset (async assert, sync deassert by design):
  - accumulator and bit_count = 0, state = DATA.
  - marker_found = 0, marker_code = 0x00.
  - s_ready = 0 while rst_n is low.
- State machine, with transitions only on accepted bytes:
  - DATA:
    - byte != 0xFF: append 8 bits below the existing valid bits.
    - byte == 0xFF: go to FF_SEEN, append nothing.
  - FF_SEEN:
    - byte 0x00: append 0xFF, go to DATA.
    - byte 0xFF: fill byte; stay in FF_SEEN, append nothing.
    - any other byte: marker_code = byte, marker_found = 1, go to MARKER. Both take effect the cycle after acceptance.
  - MARKER:
    - s_ready = 0.
    - Remaining bits stay readable via get.
    - marker_clear: bit_count = 0, accumulator cleared, marker_found = 0, marker_code retained, go to DATA on the next edge.
    - marker_clear outside MARKER is ignored.
- s_ready:
  - = rst_n && state != MARKER && bit_count <= ACC_W-8.
  - Computed from registered bit_count only; no same-cycle credit for a consume.
- bits_valid:
  - = (1 <= get_len <= MAX_GET) && bit_count >= get_len && !align_req.
  - Purely from registers and current inputs; no dependency on s_valid.
- Consume:
  - Occurs on get_req && bits_valid: bit_count -= get_len at the edge and the window shifts left by get_len.
  - bits_out is undefined-free: it always shows the top min(get_len, 16) bits; it is 0 when bit_count == 0.
- Simultaneous byte accept and consume:
  - new bit_count = bit_count - get_len + appended bits (8 or 0).
  - The new byte lands immediately after the surviving bits.
- Align:
  - align_req drops bit_count mod 8 bits, so bit_count becomes a multiple of 8.
  - It blocks get that cycle because bits_valid is 0.
  - It may coincide with a byte accept; the drop applies to the old bits, then the append.
- Latency:
  - A byte accepted at edge k is visible in bits_out and bit_count after edge k.
  - A consume at edge k updates bits_out after edge k.
- Illegal get_len (0 or >16): bits_valid = 0, nothing consumed.
- Reset mid-operation discards all bits and any pending FF_SEEN or marker state.

Test Plan:
- Bytes 0xA5, 0x3C, then four gets of len 4 -> bits_out 0xA, 0x5, 0x3, 0xC; bit_count goes 16, 12, 8, 4, 0; bits_valid low after the last get.
- Bytes 0xFF, 0x00, 0x12, get len 16 -> bits_out 0xFF12; bit_count 16 before the get and 0 after; no stuffed bits present.
- Bytes 0x55, 0xFF, 0xFF, 0xD0 -> marker_found = 1 with marker_code 0xD0 one cycle after 0xD0 is accepted, and s_ready = 0. Then:
  - get len 8 returns 0x55.
  - marker_clear -> bit_count 0, s_ready 1, state DATA.
- Four bytes 0x01..0x04 -> bit_count 32, s_ready 0. Then get len 8 with s_valid held:
  - returns 0x01, bit_count 24.
  - s_ready rises the next cycle and byte 0x05 is appended after 0x04.
- Bytes 0xA5, 0xC3, get len 3 -> 0b101. Then:
  - align_req -> bit_count 8.
  - get len 8 -> 0xC3.
  - get len 0 -> bits_valid 0, bit_count unchanged.
- Byte 0xFF, then rst_n low for 1 cycle, then byte 0x00 -> byte 0x00 is appended as data; bit_count 8, bits_out (len 8) 0x00, marker_found 0.
